// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encodings and FSM states.
package alu_mc_pkg;

  localparam int NUM_OPS = 12;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_ADC = 4'd5,
    OP_SBC = 4'd6,
    OP_CMP = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ASR = 4'd10,
    OP_MUL = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mc_addsub.sv
// Combinational adder/subtractor; cout reports borrow when sub=1 so callers
// see the carry flag semantics directly.
module alu_mc_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   full;

  // a - b - cin == a + ~b + ~cin
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
  assign full    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
  assign sum     = full[WIDTH-1:0];
  assign cout    = full[WIDTH] ^ sub;
  assign ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arith/logic, bit-serial shifts and a
// shift-add multiplier sharing one adder, with a start/busy/done handshake.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             f_z,
  output logic             f_c,
  output logic             f_n,
  output logic             f_v
);

  alu_state_e       state;
  alu_op_e          op_q;
  logic [SHAMT_W:0] cnt;
  logic [WIDTH-1:0] work, acc, mcand;
  logic [WIDTH-1:0] as_a, as_b, sum;
  logic             as_cin, as_sub, cout, ovf;
  logic [WIDTH-1:0] sh_next, logic_res, acc_next, work_next;
  logic             sh_bit;
  logic [WIDTH:0]   mul_step;
  logic [SHAMT_W-1:0] shamt;
  logic             last;

  assign shamt = b[SHAMT_W-1:0];
  assign busy  = (state != IDLE);
  assign last  = (cnt == (SHAMT_W+1)'(1));

  // The adder serves the operands while idle and the accumulator during MUL.
  always_comb begin
    as_a   = a;
    as_b   = b;
    as_sub = 1'b0;
    as_cin = 1'b0;
    if (state == MUL) begin
      as_a = acc;
      as_b = mcand;
    end else begin
      as_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
      as_cin = ((op == OP_ADC) || (op == OP_SBC)) && f_c;
    end
  end

  alu_mc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .cin  (as_cin),
    .sub  (as_sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always_comb begin
    mul_step  = work[0] ? {cout, sum} : {1'b0, acc};
    acc_next  = mul_step[WIDTH:1];
    work_next = {mul_step[0], work[WIDTH-1:1]};
  end

  always_comb begin
    sh_next = work;
    sh_bit  = 1'b0;
    case (op_q)
      OP_SHL: begin
        sh_next = {work[WIDTH-2:0], 1'b0};
        sh_bit  = work[WIDTH-1];
      end
      OP_SHR: begin
        sh_next = {1'b0, work[WIDTH-1:1]};
        sh_bit  = work[0];
      end
      OP_ASR: begin
        sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
        sh_bit  = work[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_AND:  logic_res = a & b;
      OP_OR:   logic_res = a | b;
      default: logic_res = a ^ b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ADD;
      cnt    <= '0;
      work   <= '0;
      acc    <= '0;
      mcand  <= '0;
      done   <= 1'b0;
      out    <= '0;
      out_hi <= '0;
      f_z    <= 1'b0;
      f_c    <= 1'b0;
      f_n    <= 1'b0;
      f_v    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              out    <= sum;
              out_hi <= '0;
              f_z    <= (sum == '0);
              f_n    <= sum[WIDTH-1];
              f_c    <= cout;
              f_v    <= ovf;
              done   <= 1'b1;
            end
            OP_CMP: begin
              f_z  <= (sum == '0);
              f_n  <= sum[WIDTH-1];
              f_c  <= cout;
              f_v  <= ovf;
              done <= 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
              out    <= logic_res;
              out_hi <= '0;
              f_z    <= (logic_res == '0);
              f_n    <= logic_res[WIDTH-1];
              f_c    <= 1'b0;
              f_v    <= 1'b0;
              done   <= 1'b1;
            end
            OP_SHL, OP_SHR, OP_ASR: begin
              if (shamt == '0) begin
                out    <= a;
                out_hi <= '0;
                f_z    <= (a == '0);
                f_n    <= a[WIDTH-1];
                f_v    <= 1'b0;
                done   <= 1'b1;
              end else begin
                state <= SHIFT;
                op_q  <= alu_op_e'(op);
                work  <= a;
                cnt   <= {1'b0, shamt};
              end
            end
            OP_MUL: begin
              state <= MUL;
              acc   <= '0;
              work  <= b;
              mcand <= a;
              cnt   <= (SHAMT_W+1)'(WIDTH);
            end
            default: done <= 1'b1;
          endcase
        end
        SHIFT: begin
          work <= sh_next;
          cnt  <= cnt - (SHAMT_W+1)'(1);
          if (last) begin
            state  <= IDLE;
            out    <= sh_next;
            out_hi <= '0;
            f_z    <= (sh_next == '0);
            f_n    <= sh_next[WIDTH-1];
            f_c    <= sh_bit;
            f_v    <= 1'b0;
            done   <= 1'b1;
          end
        end
        MUL: begin
          acc  <= acc_next;
          work <= work_next;
          cnt  <= cnt - (SHAMT_W+1)'(1);
          if (last) begin
            state  <= IDLE;
            out    <= work_next;
            out_hi <= acc_next;
            f_z    <= ({acc_next, work_next} == '0);
            f_n    <= acc_next[WIDTH-1];
            f_c    <= (acc_next != '0);
            f_v    <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed scenarios plus random ops checked
// against an arithmetic reference model of the opcode rules.
module tb_alu_mc;

  localparam int W = 8;

  logic         clk, rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] out, out_hi;
  logic         f_z, f_c, f_n, f_v;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_out, m_hi;
  logic         m_z, m_c, m_n, m_v;
  int           lat;

  alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .out_hi (out_hi),
    .f_z    (f_z),
    .f_c    (f_c),
    .f_n    (f_n),
    .f_v    (f_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: updates the expected architectural state and latency.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int ua, ub, sa, sb, r, sr, k, ci;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    ci = m_c ? 1 : 0;
    k  = ub % W;
    lat = 1;
    case (o)
      0, 5: begin
        r  = ua + ub + ((o == 5) ? ci : 0);
        sr = sa + sb + ((o == 5) ? ci : 0);
        m_out = r[7:0]; m_hi = 0; m_z = (r[7:0] == 0); m_n = r[7];
        m_c = (r > 255); m_v = (sr > 127) || (sr < -128);
      end
      1, 6, 7: begin
        r  = ua - ub - ((o == 6) ? ci : 0);
        sr = sa - sb - ((o == 6) ? ci : 0);
        if (o != 7) begin m_out = r[7:0]; m_hi = 0; end
        m_z = (r[7:0] == 0); m_n = r[7];
        m_c = (ua < ub + ((o == 6) ? ci : 0)); m_v = (sr > 127) || (sr < -128);
      end
      2, 3, 4: begin
        r = (o == 2) ? (ua & ub) : (o == 3) ? (ua | ub) : (ua ^ ub);
        m_out = r[7:0]; m_hi = 0; m_z = (r == 0); m_n = r[7]; m_c = 0; m_v = 0;
      end
      8, 9, 10: begin
        if (k == 0) begin
          r = ua;
        end else begin
          lat = k + 1;
          if (o == 8) begin
            r = ua << k; m_c = ((ua >> (W - k)) & 1) != 0;
          end else if (o == 9) begin
            r = ua >> k; m_c = ((ua >> (k - 1)) & 1) != 0;
          end else begin
            r = sa >>> k; m_c = ((sa >>> (k - 1)) & 1) != 0;
          end
        end
        m_out = r[7:0]; m_hi = 0; m_z = (r[7:0] == 0); m_n = r[7]; m_v = 0;
      end
      11: begin
        r = ua * ub;
        lat = W + 1;
        m_out = r[7:0]; m_hi = r[15:8]; m_z = (r == 0); m_n = r[15];
        m_c = (r[15:8] != 0); m_v = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_out"}, 32'(out), 32'(m_out));
    chk({tag, "_hi"}, 32'(out_hi), 32'(m_hi));
    chk({tag, "_flags"}, 32'({f_z, f_c, f_n, f_v}), 32'({m_z, m_c, m_n, m_v}));
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    @(negedge clk);
    chk({tag, "_idle_done"}, 32'(done), 0);
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    for (int c = 1; c < lat; c++) begin
      chk({tag, "_busy"}, 32'({busy, done}), 32'(2'b10));
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'({busy, done}), 32'(2'b01));
    check_result(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; lat = 1;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({busy, done, out, out_hi, f_z, f_c, f_n, f_v}), 0);
    rst = 1'b0;

    run_op("add_ff_01", 4'd0, 8'hFF, 8'h01);
    chk("add_ff_01_zc", 32'({f_z, f_c, out}), 32'({2'b11, 8'h00}));
    run_op("adc_10_20", 4'd5, 8'h10, 8'h20);
    chk("adc_10_20_c", 32'({f_c, out}), 32'({1'b0, 8'h31}));
    run_op("sub_80_01", 4'd1, 8'h80, 8'h01);
    run_op("sub_00_01", 4'd1, 8'h00, 8'h01);
    run_op("sbc_05_02", 4'd6, 8'h05, 8'h02);
    chk("sbc_05_02_out", 32'(out), 32'h02);
    run_op("cmp_05_05", 4'd7, 8'h05, 8'h05);
    chk("cmp_keeps_out", 32'({f_z, out}), 32'({1'b1, 8'h02}));
    run_op("shl_c1_2", 4'd8, 8'hC1, 8'd2);
    chk("shl_c1_2_res", 32'({f_c, out}), 32'({1'b1, 8'h04}));
    run_op("asr_80_7", 4'd10, 8'h80, 8'd7);
    chk("asr_80_7_res", 32'({f_n, out}), 32'({1'b1, 8'hFF}));
    run_op("shr_by0", 4'd9, 8'h5A, 8'd0);

    // MUL with an ignored start mid-flight, then back-to-back XOR in the done cycle
    @(negedge clk);
    start = 1'b1; op = 4'd11; a = 8'hFF; b = 8'hFF;
    model(4'd11, 8'hFF, 8'hFF);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < W + 1; c++) begin
      chk("mul_busy", 32'({busy, done}), 32'(2'b10));
      if (c == 4) begin
        start = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("mul_done", 32'({busy, done}), 32'(2'b01));
    chk("mul_product", 32'({out_hi, out}), 32'h0000FE01);
    chk("mul_flags", 32'({f_z, f_c, f_n, f_v}), 32'(4'b0110));
    check_result("mul_ff_ff");
    start = 1'b1; op = 4'd4; a = 8'hF0; b = 8'hFF;
    model(4'd4, 8'hF0, 8'hFF);
    @(negedge clk);
    start = 1'b0;
    chk("xor_b2b_done", 32'({busy, done}), 32'(2'b01));
    chk("xor_b2b_out", 32'(out), 32'h0F);
    check_result("xor_b2b");

    // Reset during cycle 4 of a MUL
    @(negedge clk);
    start = 1'b1; op = 4'd11; a = 8'h37; b = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mul", 32'({busy, done, out, out_hi, f_z, f_c, f_n, f_v}), 0);
    @(negedge clk);
    rst = 1'b0;
    m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      chk("rst_no_done", 32'({busy, done}), 0);
    end
    run_op("add_02_03", 4'd0, 8'h02, 8'h03);
    chk("add_02_03_out", 32'(out), 32'h05);
    run_op("nop_13", 4'd13, 8'hAA, 8'h55);
    chk("nop_13_out", 32'(out), 32'h05);

    for (int i = 0; i < 80; i++) begin
      run_op("rand", 4'($urandom_range(15, 0)), 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
